// File: rtl/led_ctrlr_x4_if.sv
// Control/status bundle between the register file and the 4-channel LED driver.
// The master side writes the control fields; the slave side reports state.
interface led_ctrlr_x4_if #(
    parameter int PWM_BITS = 8
);
    logic                  enable;
    logic [7:0]            led_mode;
    logic [15:0]           blink_half;
    logic [4*PWM_BITS-1:0] pwm_duty;
    logic [3:0]            pulse_req;
    logic [15:0]           pulse_len;
    logic [3:0]            pulse_busy;
    logic [3:0]            led_state;
    logic [3:0]            LED;

    modport master (
        output enable, led_mode, blink_half, pwm_duty, pulse_req, pulse_len,
        input  pulse_busy, led_state, LED
    );

    modport slave (
        input  enable, led_mode, blink_half, pwm_duty, pulse_req, pulse_len,
        output pulse_busy, led_state, LED
    );
endinterface

// File: rtl/led_ctrlr_x4.sv
// Four-channel LED driver: off/on/blink/PWM per channel with a
// retriggerable one-shot pulse override and optional pad inversion.
module led_ctrlr_x4 #(
    parameter int TICK_DIV       = 100000,
    parameter int PWM_BITS       = 8,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input logic          clk,
    input logic          reset,
    led_ctrlr_x4_if.slave bus
);
    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [15:0]         blink_cnt;
    logic [15:0]         blink_lim;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [3:0]          pwm_lvl;
    logic [15:0]         pulse_cnt [4];
    logic [3:0]          busy;
    logic [3:0]          led_nxt;
    logic [3:0]          led_q;

    assign tick = bus.enable && (tick_cnt == TICK_LAST);

    // A half-period of 0 behaves as 1, so the wrap limit never underflows.
    assign blink_lim = (bus.blink_half == 16'd0) ? 16'd0
                                                 : bus.blink_half - 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            pwm_cnt  <= '0;
        end else if (bus.enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            pwm_cnt  <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt >= blink_lim) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    // A fresh request takes priority over a coincident tick decrement.
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            for (int i = 0; i < 4; i++) pulse_cnt[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.pulse_req[i] && bus.pulse_len != 16'd0) begin
                    pulse_cnt[i] <= bus.pulse_len;
                    busy[i]      <= 1'b1;
                end else if (tick && busy[i]) begin
                    pulse_cnt[i] <= pulse_cnt[i] - 16'd1;
                    if (pulse_cnt[i] == 16'd1) busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pwm_lvl = '0;
        led_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            pwm_lvl[i] = pwm_cnt < bus.pwm_duty[PWM_BITS*i +: PWM_BITS];
            unique case (bus.led_mode[2*i +: 2])
                2'b00: led_nxt[i] = 1'b0;
                2'b01: led_nxt[i] = 1'b1;
                2'b10: led_nxt[i] = blink_phase;
                2'b11: led_nxt[i] = pwm_lvl[i];
            endcase
            if (busy[i]) led_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) led_q <= '0;
        else       led_q <= bus.enable ? led_nxt : 4'b0000;
    end

    assign bus.pulse_busy = busy;
    assign bus.led_state  = led_q;
    assign bus.LED        = led_q ^ {4{LED_ACTIVE_LOW}};
endmodule

// File: tb/tb_led_ctrlr_x4.sv
// Self-checking bench for led_ctrlr_x4 (TICK_DIV=4, PWM_BITS=4) plus an
// active-low instance; expected events are queued and popped on observation.
module tb_led_ctrlr_x4;
    localparam int TD = 4;
    localparam int PB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    int         q_e[$];
    int         q_l[$];
    logic [7:0] q_v[$];

    led_ctrlr_x4_if #(.PWM_BITS(PB)) bus ();
    led_ctrlr_x4_if #(.PWM_BITS(PB)) bus_al ();

    led_ctrlr_x4 #(.TICK_DIV(TD), .PWM_BITS(PB), .LED_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    led_ctrlr_x4 #(.TICK_DIV(TD), .PWM_BITS(PB), .LED_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .bus(bus_al)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edge1();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        logic [7:0] got;
        bus.enable    = 1'b1;
        bus.led_mode  = 8'h55;
        bus.pulse_len = 16'd5;
        bus.pulse_req = 4'hF;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q_v.push_back(8'h00);
            edge1();
            got = {bus.LED, bus.pulse_busy};
            exp = q_v.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got %h want %h", k, got, exp);
            end
        end
        bus.pulse_req = 4'h0;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q_v.push_back(8'hF0);
            edge1();
            got = {bus.LED, bus.pulse_busy};
            exp = q_v.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release%0d: got %h want %h", k, got, exp);
            end
        end
    endtask

    task automatic test_blink();
        logic prev;
        int   exp;
        bus.led_mode   = 8'h02;
        bus.blink_half = 16'd2;
        bus.pulse_len  = 16'd0;
        q_e.delete();
        q_e.push_back(9);
        q_e.push_back(17);
        q_e.push_back(25);
        do_reset();
        prev = bus.LED[0];
        n_chk++;
        if (prev !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_start: got %b want 0", prev);
        end
        for (int e = 1; e <= 32; e++) begin
            edge1();
            if (bus.LED[0] !== prev) begin
                prev = bus.LED[0];
                n_chk++;
                if (q_e.size() == 0) begin
                    n_fail++;
                    $display("FAIL blink_extra: toggle at edge %0d want none", e);
                end else begin
                    exp = q_e.pop_front();
                    if (e != exp) begin
                        n_fail++;
                        $display("FAIL blink_edge: got edge %0d want %0d", e, exp);
                    end
                end
            end
        end
        n_chk++;
        if (q_e.size() != 0) begin
            n_fail++;
            $display("FAIL blink_missing: got %0d left want 0", q_e.size());
        end
    endtask

    task automatic test_blink_shrink();
        logic prev;
        int   exp;
        bus.led_mode   = 8'h02;
        bus.blink_half = 16'd4;
        q_e.delete();
        q_e.push_back(13);
        q_e.push_back(17);
        do_reset();
        prev = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            edge1();
            if (e == 9) bus.blink_half = 16'd0;
            if (bus.LED[0] !== prev) begin
                prev = bus.LED[0];
                n_chk++;
                if (q_e.size() == 0) begin
                    n_fail++;
                    $display("FAIL shrink_extra: toggle at edge %0d want none", e);
                end else begin
                    exp = q_e.pop_front();
                    if (e != exp) begin
                        n_fail++;
                        $display("FAIL shrink_edge: got edge %0d want %0d", e, exp);
                    end
                end
            end
        end
        n_chk++;
        if (q_e.size() != 0) begin
            n_fail++;
            $display("FAIL shrink_missing: got %0d left want 0", q_e.size());
        end
    endtask

    task automatic test_pwm();
        int lit;
        int exp;
        bus.led_mode = 8'h0C;
        bus.pwm_duty = 16'h0040;
        q_e.delete();
        q_e.push_back(4);
        q_e.push_back(0);
        q_e.push_back(15);
        do_reset();
        for (int w = 0; w < 3; w++) begin
            lit = 0;
            for (int s = 0; s < 16; s++) begin
                edge1();
                if (w == 0 && s == 0) begin
                    n_chk++;
                    if (bus.LED[1] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL pwm_first: got %b want 1", bus.LED[1]);
                    end
                end
                lit += int'(bus.LED[1]);
            end
            if (w == 0) bus.pwm_duty = 16'h0000;
            if (w == 1) bus.pwm_duty = 16'h00F0;
            exp = q_e.pop_front();
            n_chk++;
            if (lit != exp) begin
                n_fail++;
                $display("FAIL pwm_window%0d: got %0d lit want %0d", w, lit, exp);
            end
        end
        bus.pwm_duty = 16'h0000;
    endtask

    task automatic test_pulse();
        logic pb;
        logic pl;
        int   exp;
        bus.led_mode  = 8'h00;
        bus.pulse_len = 16'd3;
        q_e.delete();
        q_l.delete();
        q_e.push_back(1);
        q_e.push_back(12);
        q_l.push_back(2);
        q_l.push_back(13);
        do_reset();
        bus.pulse_req = 4'b0100;
        pb = 1'b0;
        pl = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            if (e == 1) bus.pulse_req = 4'b0000;
            if (bus.pulse_busy[2] !== pb) begin
                pb = bus.pulse_busy[2];
                exp = (q_e.size() != 0) ? q_e.pop_front() : -1;
                n_chk++;
                if (e != exp) begin
                    n_fail++;
                    $display("FAIL pulse_busy: got edge %0d want %0d", e, exp);
                end
            end
            if (bus.LED[2] !== pl) begin
                pl = bus.LED[2];
                exp = (q_l.size() != 0) ? q_l.pop_front() : -1;
                n_chk++;
                if (e != exp) begin
                    n_fail++;
                    $display("FAIL pulse_led: got edge %0d want %0d", e, exp);
                end
            end
        end
        n_chk++;
        if (q_e.size() + q_l.size() != 0) begin
            n_fail++;
            $display("FAIL pulse_missing: got %0d left want 0", q_e.size() + q_l.size());
        end
    endtask

    task automatic test_retrigger();
        logic pb;
        logic pl;
        int   exp;
        bus.led_mode  = 8'h00;
        bus.pulse_len = 16'd3;
        q_e.delete();
        q_l.delete();
        q_e.push_back(1);
        q_e.push_back(20);
        q_l.push_back(2);
        q_l.push_back(21);
        do_reset();
        bus.pulse_req = 4'b0100;
        pb = 1'b0;
        pl = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            edge1();
            bus.pulse_req = 4'b0000;
            bus.pulse_len = 16'd3;
            if (e == 7) bus.pulse_req = 4'b0100;
            if (e == 13 || e == 24) begin
                bus.pulse_len = 16'd0;
                bus.pulse_req = 4'b0100;
            end
            if (bus.pulse_busy[2] !== pb) begin
                pb = bus.pulse_busy[2];
                exp = (q_e.size() != 0) ? q_e.pop_front() : -1;
                n_chk++;
                if (e != exp) begin
                    n_fail++;
                    $display("FAIL retrig_busy: got edge %0d want %0d", e, exp);
                end
            end
            if (bus.LED[2] !== pl) begin
                pl = bus.LED[2];
                exp = (q_l.size() != 0) ? q_l.pop_front() : -1;
                n_chk++;
                if (e != exp) begin
                    n_fail++;
                    $display("FAIL retrig_led: got edge %0d want %0d", e, exp);
                end
            end
        end
        bus.pulse_req = 4'b0000;
        n_chk++;
        if (q_e.size() + q_l.size() != 0) begin
            n_fail++;
            $display("FAIL retrig_missing: got %0d left want 0", q_e.size() + q_l.size());
        end
    endtask

    task automatic test_enable();
        logic [16:0] led3;
        logic [16:0] bsy3;
        logic [7:0]  got;
        logic [7:0]  exp;
        led3 = 17'b1_0000_1100_0011_1110;
        bsy3 = 17'b0_0000_0000_0011_1111;
        bus.led_mode   = 8'h80;
        bus.blink_half = 16'd1;
        bus.pulse_len  = 16'd8;
        q_v.delete();
        do_reset();
        bus.pulse_req = 4'b1000;
        for (int e = 1; e <= 17; e++) begin
            q_v.push_back({led3[e-1], 3'b000, bsy3[e-1], 3'b000});
            edge1();
            bus.pulse_req = 4'b0000;
            if (e == 6)  bus.enable = 1'b0;
            if (e == 8)  bus.pulse_req = 4'b1000;
            if (e == 10) bus.enable = 1'b1;
            got = {bus.LED, bus.pulse_busy};
            exp = q_v.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_e%0d: got %h want %h", e, got, exp);
            end
        end
    endtask

    task automatic test_active_low();
        logic [7:0] got;
        logic [7:0] exp;
        q_v.delete();
        q_v.push_back(8'h0F);
        q_v.push_back(8'hF0);
        edge1();
        edge1();
        got = {bus_al.LED, bus_al.led_state};
        exp = q_v.pop_front();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL al_run: got %h want %h", got, exp);
        end
        reset = 1'b1;
        edge1();
        got = {bus_al.LED, bus_al.led_state};
        exp = q_v.pop_front();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL al_reset: got %h want %h", got, exp);
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.enable        = 1'b1;
        bus.led_mode      = 8'h00;
        bus.blink_half    = 16'd1;
        bus.pwm_duty      = '0;
        bus.pulse_req     = 4'h0;
        bus.pulse_len     = 16'd0;
        bus_al.enable     = 1'b1;
        bus_al.led_mode   = 8'h55;
        bus_al.blink_half = 16'd1;
        bus_al.pwm_duty   = '0;
        bus_al.pulse_req  = 4'h0;
        bus_al.pulse_len  = 16'd0;
        #1;
        test_reset();
        test_blink();
        test_blink_shrink();
        test_pwm();
        test_pulse();
        test_retrigger();
        test_enable();
        test_active_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
